// File: rtl/stoch_pkg.sv
// Shared types and sizing helpers for the stochastic encode/decode blocks.
package stoch_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    // Window length in samples for a given result width.
    function automatic int unsigned win_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage

// File: rtl/stoch_window_counter.sv
// Counts valid samples and ones over a window of 2^WIDTH valid samples.
module stoch_window_counter
    import stoch_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           en,
    input  logic           bit_in,
    output logic [WIDTH:0] ones_cnt,
    output logic [WIDTH:0] sample_cnt,
    output logic           last
);

    localparam int unsigned    N        = win_len(WIDTH);
    localparam logic [WIDTH:0] LAST_IDX = (WIDTH + 1)'(N - 1);

    always_ff @(posedge clk) begin
        if (clr) begin
            ones_cnt   <= '0;
            sample_cnt <= '0;
        end else if (en) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_cnt   <= ones_cnt + {{WIDTH{1'b0}}, bit_in};
        end
    end

    assign last = en && (sample_cnt == LAST_IDX);

endmodule

// File: rtl/stoch_to_bin_decoder.sv
// Stochastic-to-binary decoder: counts ones over a 2^WIDTH-sample window and
// presents the saturated count behind a valid/ready handshake.
module stoch_to_bin_decoder
    import stoch_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic [WIDTH-1:0] out_value,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned    N     = win_len(WIDTH);
    localparam logic [WIDTH:0] N_CNT = (WIDTH + 1)'(N);

    state_t         state;
    logic [WIDTH:0] ones_cnt;
    logic [WIDTH:0] sample_cnt;
    logic [WIDTH:0] final_cnt;
    logic           last;
    logic           cnt_clr;
    logic           cnt_en;
    logic           handshake;
    logic           sat;

    assign handshake = (state == HOLD) && out_valid && out_ready;
    // Counters clear whenever a new window opens, including a start that
    // coincides with the result handshake.
    assign cnt_clr   = rst || ((state == IDLE) && start) || (handshake && start);
    assign cnt_en    = (state == RUN) && bit_valid;
    // The closing sample is still in flight on the last cycle, so fold it in.
    assign final_cnt = ones_cnt + {{WIDTH{1'b0}}, bit_in};
    assign sat       = (final_cnt == N_CNT);
    assign busy      = (state == RUN);

    stoch_window_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk       (clk),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .bit_in    (bit_in),
        .ones_cnt  (ones_cnt),
        .sample_cnt(sample_cnt),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_value <= '0;
            out_sat   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (last) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_value <= sat ? '1 : final_cnt[WIDTH-1:0];
                        out_sat   <= sat;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= start ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sample_cnt_bounded: assert property (@(posedge clk) disable iff (rst) sample_cnt <= N_CNT);

endmodule

// File: tb/tb_stoch_to_bin_decoder.sv
// Directed bench for stoch_to_bin_decoder (WIDTH=4) with a queue-based window model.
module tb_stoch_to_bin_decoder;

    localparam int unsigned WIDTH = 4;
    localparam int          N     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             bit_in;
    logic             bit_valid;
    logic             busy;
    logic [WIDTH-1:0] out_value;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;

    int total = 0;
    int bad   = 0;

    stoch_to_bin_decoder #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .busy     (busy),
        .out_value(out_value),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a window is a list of collected samples; the result is their sum.
    logic m_open  = 1'b0;
    logic m_valid = 1'b0;
    int   m_value = 0;
    logic m_sat   = 1'b0;
    int   m_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_open  = 1'b0;
            m_valid = 1'b0;
            m_value = 0;
            m_sat   = 1'b0;
            m_q.delete();
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                if (start) begin
                    m_open = 1'b1;
                    m_q.delete();
                end
            end
        end else if (m_open) begin
            if (bit_valid) m_q.push_back(int'(bit_in));
            if (m_q.size() == N) begin
                int s;
                s = 0;
                foreach (m_q[i]) s += m_q[i];
                m_open  = 1'b0;
                m_valid = 1'b1;
                m_sat   = (s == N);
                m_value = (s > N - 1) ? N - 1 : s;
            end
        end else if (start) begin
            m_open = 1'b1;
            m_q.delete();
        end
    end

    always @(posedge clk) begin
        #2;
        check("cyc_busy", 32'(busy), 32'(m_open));
        check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
        check("cyc_out_value", 32'(out_value), 32'(m_value));
        check("cyc_out_sat", 32'(out_sat), 32'(m_sat));
    end

    // Drive one cycle of inputs, then advance to the next negedge.
    task automatic cyc(input logic s, input logic v, input logic b, input logic r);
        start     = s;
        bit_valid = v;
        bit_in    = b;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic send(input logic b);
        cyc(1'b0, 1'b1, b, 1'b0);
    endtask

    // Called right after the last sample: result must already be valid.
    task automatic expect_result(input string name, input int ev, input logic es);
        int waited;
        waited = 0;
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
        while (!out_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_latency"}, 32'(waited), 32'd0);
        check({name, "_value"}, 32'(out_value), 32'(ev));
        check({name, "_sat"}, 32'(out_sat), 32'(es));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_value", 32'(out_value), 32'd0);
        rst = 1'b0;

        // All ones saturates.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) send(1'b1);
        expect_result("ones", 15, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ones_drop_valid", 32'(out_valid), 32'd0);
        check("ones_idle", 32'(busy), 32'd0);
        check("ones_value_held", 32'(out_value), 32'd15);

        // Alternating, then handshake with start straight into an all-zero window.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) send(logic'(i % 2 == 0));
        expect_result("alt", 8, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("alt_restart_busy", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) send(1'b0);
        expect_result("zeros", 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Five ones with a three-cycle gap that must not count.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (i == 8) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(1'b0, 1'b0, 1'b1, 1'b0);
                    check("gap_busy", 32'(busy), 32'd1);
                end
            end
            send(logic'(i < 5));
        end
        expect_result("gap", 5, 1'b0);

        // Backpressure: result holds while inputs churn.
        for (int i = 0; i < 10; i++) cyc(logic'(i % 2), logic'(i % 3 == 0), logic'(i % 2 == 1), 1'b0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_value", 32'(out_value), 32'd5);
        check("bp_sat", 32'(out_sat), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("bp_restart_busy", 32'(busy), 32'd1);
        check("bp_restart_valid", 32'(out_valid), 32'd0);

        // Fresh window: start pulsed mid-run is ignored; 2 + 12 ones.
        send(1'b1); send(1'b1); send(1'b0); send(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("midstart_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 12; i++) send(1'b1);
        expect_result("midstart", 14, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-window discards the partial count.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send(1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) send(logic'(i < 3));
        expect_result("after_rst", 3, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
